// File: rtl/sfifo_pkg.sv
// Shared constants for the sfifo and the blocks that talk to it.
package sfifo_pkg;

  localparam int DW         = 16;  // FIFO data width
  localparam int FIFO_DEPTH = 64;  // FIFO entries
  localparam int RD_LAT     = 2;   // cycles from rd_in to dout valid

  // Pointer width for a circular buffer of the given depth (at least 1 bit).
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sfifo_drain_buf.sv
// Circular output buffer for sfifo_drain. The head entry drives the output
// stream; push and pop may happen in the same cycle. The caller guarantees
// no push into a full buffer.
module sfifo_drain_buf
  import sfifo_pkg::*;
#(
  parameter int WIDTH = DW,
  parameter int DEPTH = 4,
  localparam int PW = ptr_w(DEPTH),
  localparam int OW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data,
  output logic [OW-1:0]    occ
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Storage: data entries carry no reset, only the pointers and count do.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Head is only meaningful when occupied; show zero otherwise.
  assign head_valid = (occ != '0);
  assign head_data  = head_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/sfifo_drain.sv
// Read-side master for the sfifo. Issues speculative reads to hide the
// FIFO's two-cycle read latency, treats udfl as a per-request cancel and
// delivers the words on a valid/ready stream.
//
// Handshake: a word moves from m_data to the consumer in every cycle where
// m_valid=1 and m_ready=1; m_valid never drops and m_data never changes
// while m_valid=1 and m_ready=0.
module sfifo_drain #(
  parameter int DW        = sfifo_pkg::DW,
  parameter int OUT_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             fifo_rd,
  input  logic [DW-1:0]    fifo_dout,
  input  logic             fifo_empty,
  input  logic             fifo_udfl,
  output logic             m_valid,
  output logic [DW-1:0]    m_data,
  input  logic             m_ready,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic             busy
);

  localparam int OW = $clog2(OUT_DEPTH + 1);
  localparam int SW = OW + 2;

  logic          s1;           // FIFO is performing the read this cycle
  logic          s2;           // fifo_dout holds a fresh word this cycle
  logic          pop;
  logic          issue;
  logic [OW-1:0] occ;
  logic [SW-1:0] credit_used;

  assign pop = m_valid & m_ready;

  // Credit check: every buffer slot is claimed by a held word or a request
  // still in flight (cancelled ones included, until they resolve).
  always_comb begin
    credit_used = SW'(occ) - SW'(pop) + SW'(s1) + SW'(s2) + SW'(fifo_rd);
    issue       = en & ~fifo_empty & (credit_used < SW'(OUT_DEPTH));
  end

  // Request pipeline: fifo_rd -> s1 (FIFO reads) -> s2 (dout valid).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_rd <= 1'b0;
      s1      <= 1'b0;
      s2      <= 1'b0;
    end else begin
      fifo_rd <= issue;
      s1      <= fifo_rd;
      s2      <= s1 & ~fifo_udfl;
    end
  end

  // Statistics: delivered words and cancelled speculative reads, wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_cnt <= '0;
      miss_cnt <= '0;
    end else begin
      if (pop)             word_cnt <= word_cnt + CNT_W'(1);
      if (s1 && fifo_udfl) miss_cnt <= miss_cnt + CNT_W'(1);
    end
  end

  sfifo_drain_buf #(
    .WIDTH (DW),
    .DEPTH (OUT_DEPTH)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (s2),
    .push_data  (fifo_dout),
    .pop        (pop),
    .head_valid (m_valid),
    .head_data  (m_data),
    .occ        (occ)
  );

  assign busy = s1 | s2 | fifo_rd | (occ != '0);

endmodule

// File: tb/tb_sfifo_drain.sv
// Bench for sfifo_drain: behavioural sfifo model on the read side, random
// data and backpressure, scoreboard of words in FIFO write order.
module tb_sfifo_drain;
  import sfifo_pkg::*;

  localparam int OUT_DEPTH = 4;
  localparam int CNT_W     = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic             en = 1'b0;
  logic             m_ready = 1'b0;
  logic             fifo_rd;
  logic [DW-1:0]    fifo_dout;
  logic             fifo_empty;
  logic             fifo_udfl;
  logic             m_valid;
  logic [DW-1:0]    m_data;
  logic [CNT_W-1:0] word_cnt;
  logic [CNT_W-1:0] miss_cnt;
  logic             busy;

  sfifo_drain #(.DW(DW), .OUT_DEPTH(OUT_DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fifo_rd    (fifo_rd),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_udfl  (fifo_udfl),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .word_cnt   (word_cnt),
    .miss_cnt   (miss_cnt),
    .busy       (busy)
  );

  // ---------------- sfifo model (write side driven by the bench) ----------------
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] fmem [FIFO_DEPTH];
  int            f_wp, f_rp, f_cnt;
  logic          rd_int;
  logic          f_rd, f_wr;

  assign fifo_empty = (f_cnt == 0);
  assign fifo_udfl  = rd_int && (f_cnt == 0);
  assign f_rd       = rd_int && (f_cnt != 0);
  assign f_wr       = wr_en && (f_cnt < FIFO_DEPTH);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_int    <= 1'b0;
      f_wp      <= 0;
      f_rp      <= 0;
      f_cnt     <= 0;
      fifo_dout <= '0;
    end else begin
      rd_int <= fifo_rd;
      if (f_wr) begin
        fmem[f_wp] <= wr_data;
        f_wp       <= (f_wp + 1) % FIFO_DEPTH;
      end
      if (f_rd) begin
        fifo_dout <= fmem[f_rp];
        f_rp      <= (f_rp + 1) % FIFO_DEPTH;
      end
      f_cnt <= f_cnt + (f_wr ? 1 : 0) - (f_rd ? 1 : 0);
    end
  end

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int            pop_cyc[$];
  int n_checks = 0, n_pass = 0;
  int cyc = 0, n_rd = 0, n_miss = 0, n_reads = 0, n_pops = 0, max_held = 0;
  bit ovfl_seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Per-cycle monitor, sampled mid-cycle.
  always @(negedge clk) begin
    logic [DW-1:0] exp_w;
    if (rst) begin
      cyc++;
      if (fifo_rd)   n_rd++;
      if (fifo_udfl) n_miss++;
      if (f_rd)      n_reads++;
      if (wr_en && f_cnt == FIFO_DEPTH) ovfl_seen = 1'b1;
      if (m_valid && m_ready) begin
        chk("out_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_w = exp_q.pop_front();
          chk("m_data", m_data, exp_w);
        end
        n_pops++;
        pop_cyc.push_back(cyc);
      end
      if (n_reads - n_pops > max_held) max_held = n_reads - n_pops;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fifo_write(input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    exp_q.push_back(d);
    tick(1);
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (!(exp_q.size() == 0 && busy == 1'b0) && n < budget) begin
      tick(1);
      n++;
    end
    chk(tag, n < budget, 1);
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_word_cnt"}, word_cnt, n_pops & 32'hFFFF);
    chk({tag, "_miss_cnt"}, miss_cnt, n_miss & 32'hFFFF);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int base_rd, base_miss, base_pops, base_reads, written, n;
    bit found;

    // Reset state
    #3;
    chk("rst_fifo_rd", fifo_rd, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    chk("rst_busy", busy, 0);
    tick(2);
    rst = 1'b1;
    tick(2);

    // 1: eight sequential words, streamed one per cycle
    for (int i = 1; i <= 8; i++) fifo_write(DW'(i));
    pop_cyc.delete();
    en = 1'b1;
    m_ready = 1'b1;
    wait_idle("t1_idle", 50);
    chk("t1_pops", pop_cyc.size(), 8);
    if (pop_cyc.size() == 8) chk("t1_burst", pop_cyc[7] - pop_cyc[0], 7);
    chk("t1_fifo_empty", f_cnt, 0);
    chk("t1_ovfl", ovfl_seen, 0);
    check_counters("t1");

    // 2: single word; every read after the first is cancelled
    base_rd = n_rd; base_miss = n_miss; base_pops = n_pops;
    fifo_write(16'hA5A5);
    wait_idle("t2_idle", 50);
    chk("t2_pops", n_pops - base_pops, 1);
    chk("t2_miss_vs_rd", n_miss - base_miss, n_rd - base_rd - 1);
    check_counters("t2");

    // 3: full FIFO with backpressure, then drain across the pointer wrap
    en = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) fifo_write(DW'($urandom));
    base_reads = n_reads; base_pops = n_pops;
    en = 1'b1;
    tick(20);
    chk("t3_reads_held", n_reads - base_reads, OUT_DEPTH);
    chk("t3_m_valid", m_valid, 1);
    chk("t3_head", m_data, exp_q[0]);
    chk("t3_no_pop", n_pops - base_pops, 0);
    check_counters("t3a");
    m_ready = 1'b1;
    wait_idle("t3_idle", 200);
    chk("t3_pops", n_pops - base_pops, FIFO_DEPTH);
    check_counters("t3b");

    // 4: random backpressure, FIFO fed one word per two cycles
    base_pops = n_pops;
    written = 0;
    for (int i = 0; i < 2000 && written < 200; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      if (i % 2 == 0 && f_cnt < FIFO_DEPTH) begin
        wr_en   = 1'b1;
        wr_data = DW'($urandom);
        exp_q.push_back(wr_data);
        written++;
      end else begin
        wr_en = 1'b0;
      end
      tick(1);
    end
    wr_en = 1'b0;
    m_ready = 1'b1;
    wait_idle("t4_idle", 400);
    chk("t4_pops", n_pops - base_pops, 200);
    check_counters("t4");

    // 5: en dropped after three reads issued, words left in the FIFO
    en = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) fifo_write(DW'($urandom));
    base_rd = n_rd; base_pops = n_pops;
    en = 1'b1;
    tick(3);
    en = 1'b0;
    tick(10);
    chk("t5_rd_issued", n_rd - base_rd, 3);
    chk("t5_busy_held", busy, 1);
    m_ready = 1'b1;
    n = 0;
    while (busy && n < 20) begin tick(1); n++; end
    chk("t5_busy_low", busy, 0);
    chk("t5_pops", n_pops - base_pops, 3);
    chk("t5_no_new_rd", n_rd - base_rd, 3);
    chk("t5_fifo_left", f_cnt, 7);
    en = 1'b1;
    wait_idle("t5_idle", 50);
    chk("t5_pops_all", n_pops - base_pops, 10);
    check_counters("t5");

    // 6: reset with requests in flight and words buffered
    en = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) fifo_write(DW'($urandom));
    en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (dut.s1 && dut.s2 && dut.u_buf.occ == 2) found = 1'b1;
      else tick(1);
    end
    chk("t6_precond", found, 1);
    rst = 1'b0;
    exp_q.delete();
    n_pops = 0; n_miss = 0; n_reads = 0; n_rd = 0;
    #1;
    chk("t6_m_valid", m_valid, 0);
    chk("t6_fifo_rd", fifo_rd, 0);
    chk("t6_word_cnt", word_cnt, 0);
    chk("t6_miss_cnt", miss_cnt, 0);
    chk("t6_busy", busy, 0);
    tick(2);
    rst = 1'b1;
    m_ready = 1'b1;
    tick(1);
    for (int i = 0; i < 5; i++) fifo_write(DW'($urandom));
    wait_idle("t6_idle", 50);
    chk("t6_pops", n_pops, 5);
    check_counters("t6");

    // Global invariants
    chk("max_held_bound", max_held <= OUT_DEPTH, 1);
    chk("fifo_ovfl", ovfl_seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
